// File: rtl/icu_seq_pkg.sv
// icu_seq_pkg: shared types and constants of the ICU fetch/issue sequencer.
package icu_seq_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_IO_W        = 3;
    localparam int DEF_STACK_DEPTH = 4;

    // Opcode position inside a ROM word, counted above the ADDR_W-bit operand.
    localparam int OPC_W   = 4;
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = OPC_LSB + OPC_W - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_DECODE  = 3'd3,
        S_RELEASE = 3'd4,
        S_HALT    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/instructions_pkg.sv
// instructions_pkg: 4-bit instruction encoding of the 1-bit ICU.
package instructions_pkg;

    typedef enum logic [3:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } instruction_t;

endpackage

// File: rtl/icu_sequencer_if.sv
// icu_sequencer_if: program-ROM port plus ICU req/ack handshake and decode flags.
interface icu_sequencer_if
    import icu_seq_pkg::*;
    import instructions_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IO_W   = DEF_IO_W
) ();

    logic [ADDR_W-1:0]       prog_addr;
    logic [OPC_W+ADDR_W-1:0] prog_data;
    instruction_t            instr;
    logic [IO_W-1:0]         io_addr;
    logic                    icu_req;
    logic                    icu_ack;
    logic                    icu_jmp;
    logic                    icu_rtn;
    logic                    icu_flag_o;
    logic                    icu_flag_f;

    // Sequencer side.
    modport master (
        output prog_addr, instr, io_addr, icu_req,
        input  prog_data, icu_ack, icu_jmp, icu_rtn, icu_flag_o, icu_flag_f
    );

    // ROM + ICU side.
    modport slave (
        input  prog_addr, instr, io_addr, icu_req,
        output prog_data, icu_ack, icu_jmp, icu_rtn, icu_flag_o, icu_flag_f
    );

endinterface

// File: rtl/icu_ret_stack.sv
// icu_ret_stack: small LIFO of return addresses for ICU subroutine calls.
module icu_ret_stack
    import icu_seq_pkg::*;
#(
    parameter int DEPTH = DEF_STACK_DEPTH,
    parameter int W     = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // sp_q counts stored entries, 0..DEPTH; its low bits index the next free slot.
    logic [PTR_W:0]   sp_q;
    logic [PTR_W-1:0] top_idx;
    logic [W-1:0]     mem_q [DEPTH];

    assign full_o  = (sp_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_idx = sp_q[PTR_W-1:0] - PTR_W'(1);
    assign data_o  = mem_q[top_idx];

    // Stack pointer: push and pop are ignored when they would over/underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            sp_q <= sp_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - 1'b1;
        end
    end

    // Entry storage.
    // NOTE: storage is deliberately left out of reset; an entry is never read before it is pushed.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[sp_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/icu_sequencer.sv
// icu_sequencer: PC owner, ROM fetch and 4-phase req/ack issue to the 1-bit ICU.
// Optional build macro SEQ_BREAKPOINT_EN adds bp_valid_i/bp_addr_i: a fetch of
// bp_addr_i stops in IDLE, and a 0->1 edge on run_i executes that word once.
module icu_sequencer
    import icu_seq_pkg::*;
    import instructions_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int IO_W        = DEF_IO_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
`ifdef SEQ_BREAKPOINT_EN
    input  logic              bp_valid_i,
    input  logic [ADDR_W-1:0] bp_addr_i,
`endif
    icu_sequencer_if.master   bus,
    output logic              halted_o,
    output logic              stack_err_o
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    instruction_t      instr_q, instr_d;
    logic [ADDR_W-1:0] operand_q, operand_d;
    logic              halt_pend_q, halt_pend_d;
    logic              stack_err_q, stack_err_d;

    logic              stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;
    logic              bp_stop_idle, bp_stop_rel;

`ifdef SEQ_BREAKPOINT_EN
    logic run_prev_q;
    logic bp_match;

    assign bp_match     = bp_valid_i && (pc_q == bp_addr_i);
    // A fresh run edge lets the breakpoint word through once.
    assign bp_stop_idle = bp_match && !(run_i && !run_prev_q);
    assign bp_stop_rel  = bp_match;

    // Previous run level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_prev_q <= 1'b0;
        end else begin
            run_prev_q <= run_i;
        end
    end
`else
    assign bp_stop_idle = 1'b0;
    assign bp_stop_rel  = 1'b0;
`endif

    icu_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (pc_q),
        .data_o  (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    // Next-state, next-PC and stack control.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        operand_d   = operand_q;
        halt_pend_d = halt_pend_q;
        stack_err_d = stack_err_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_i && !bp_stop_idle) begin
                    state_d = S_FETCH;
                end
            end

            // prog_addr follows the PC, which has been stable for at least one
            // clk on every path into FETCH, so the ROM word is valid here.
            S_FETCH: begin
                instr_d   = instruction_t'(bus.prog_data[ADDR_W+OPC_MSB:ADDR_W+OPC_LSB]);
                operand_d = bus.prog_data[ADDR_W-1:0];
                state_d   = S_ISSUE;
            end

            S_ISSUE: begin
                if (bus.icu_ack) begin
                    state_d = S_DECODE;
                end
            end

            // Flags have settled by now; priority flag_f > rtn > flag_o > jmp.
            S_DECODE: begin
                state_d = S_RELEASE;
                if (bus.icu_flag_f) begin
                    halt_pend_d = 1'b1;
                    pc_d        = pc_q + 1'b1;
                end else if (bus.icu_rtn) begin
                    if (stk_empty) begin
                        stack_err_d = 1'b1;
                        halt_pend_d = 1'b1;
                    end else begin
                        stk_pop = 1'b1;
                        pc_d    = stk_top;
                    end
                end else if (bus.icu_flag_o) begin
                    if (stk_full) begin
                        stack_err_d = 1'b1;
                        halt_pend_d = 1'b1;
                    end else begin
                        stk_push = 1'b1;
                        pc_d     = operand_q;
                    end
                end else if (bus.icu_jmp) begin
                    pc_d = operand_q;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end

            S_RELEASE: begin
                if (!bus.icu_ack) begin
                    if (halt_pend_q) begin
                        state_d = S_HALT;
                    end else if (run_i && !bp_stop_rel) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            instr_q     <= NOPO;
            operand_q   <= '0;
            halt_pend_q <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            operand_q   <= operand_d;
            halt_pend_q <= halt_pend_d;
            stack_err_q <= stack_err_d;
        end
    end

    // req is a pure decode of the state register, so reset drops it at once.
    assign bus.prog_addr = pc_q;
    assign bus.instr     = instr_q;
    assign bus.io_addr   = operand_q[IO_W-1:0];
    assign bus.icu_req   = (state_q == S_ISSUE);
    assign halted_o      = (state_q == S_IDLE) || (state_q == S_HALT);
    assign stack_err_o   = stack_err_q;

endmodule
